// File: rtl/huff_pkg.sv
// Shared constants, code table and FSM state type for the streaming Huffman decoder.
package huff_pkg;

  localparam int unsigned MAX_LEN   = 6;
  localparam int unsigned SYM_W     = 4;
  localparam int unsigned LEN_W     = $clog2(MAX_LEN + 1);
  localparam int unsigned NUM_CODES = 14;

  // Codes are stored MSB-aligned in a MAX_LEN-bit field; unused low bits are 0.
  localparam logic [MAX_LEN-1:0] CODE_BITS [NUM_CODES] = '{
    6'b100000, 6'b011100, 6'b010100, 6'b010000, 6'b001100, 6'b001000, 6'b000000,
    6'b011010, 6'b011000, 6'b011001, 6'b000110, 6'b000111, 6'b000100, 6'b000101
  };

  localparam logic [LEN_W-1:0] CODE_LEN [NUM_CODES] = '{
    3'd1, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4,
    3'd5, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6
  };

  localparam logic [SYM_W-1:0] CODE_SYM [NUM_CODES] = '{
    4'd0, 4'd9, 4'd2, 4'd1, 4'd6, 4'd5, 4'd10,
    4'd7, 4'd3, 4'd4, 4'd8, 4'd12, 4'd14, 4'd15
  };

  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
    return ~({MAX_LEN{1'b1}} >> len);
  endfunction

endpackage

// File: rtl/huff_code_match.sv
// Combinational prefix matcher: maps an MSB-first window to its symbol and code length.
module huff_code_match
  import huff_pkg::*;
(
  input  logic [MAX_LEN-1:0] window,
  output logic [SYM_W-1:0]   symbol,
  output logic [LEN_W-1:0]   length
);

  // The table is prefix-free, so at most one entry can hit.
  always_comb begin
    symbol = '0;
    length = '0;
    for (int unsigned i = 0; i < NUM_CODES; i++) begin
      if ((window & len_mask(CODE_LEN[i])) == CODE_BITS[i]) begin
        symbol = CODE_SYM[i];
        length = CODE_LEN[i];
      end
    end
  end

endmodule

// File: rtl/huffman_stream_decoder.sv
// Streaming Huffman decoder: packs IN_W-bit chunks into a bit buffer and emits up to
// one symbol per clock with valid/ready on both sides plus end-of-frame reporting.
module huffman_stream_decoder
  import huff_pkg::*;
#(
  parameter int unsigned IN_W  = 6,
  parameter int unsigned BUF_W = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_W-1:0]            in_data,
  input  logic [$clog2(IN_W+1)-1:0]  in_nbits,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SYM_W-1:0]           out_symbol,
  output logic [LEN_W-1:0]           out_length,
  output logic                       frame_done,
  output logic                       trunc_err,
  output logic [CNT_W-1:0]           sym_count
);

  localparam int unsigned CW = $clog2(BUF_W + 1);

  if (BUF_W < IN_W + MAX_LEN) begin : g_buf_too_small
    $error("huffman_stream_decoder: BUF_W must be >= IN_W + MAX_LEN");
  end

  state_t            state, state_nxt;
  logic [BUF_W-1:0]  bit_buf, buf_shift, in_aligned;
  logic [CW-1:0]     count, cnt_after;
  logic [IN_W-1:0]   data_masked;
  logic [SYM_W-1:0]  m_sym;
  logic [LEN_W-1:0]  m_len;
  logic              match_valid, fire, accept, handshake, new_frame;

  huff_code_match u_match (
    .window (bit_buf[BUF_W-1 -: MAX_LEN]),
    .symbol (m_sym),
    .length (m_len)
  );

  assign in_ready    = (state == RUN) && (count <= CW'(BUF_W - IN_W));
  assign accept      = in_valid && in_ready;
  assign match_valid = (state != DONE) && (m_len != '0) && (CW'(m_len) <= count);
  assign fire        = match_valid && (!out_valid || out_ready);
  assign handshake   = out_valid && out_ready;

  // Bits below count are kept zero, so new data can simply be OR-ed in under the survivors.
  always_comb begin
    cnt_after   = fire ? count - CW'(m_len) : count;
    buf_shift   = fire ? bit_buf << m_len : bit_buf;
    data_masked = in_data & ~({IN_W{1'b1}} >> in_nbits);
    in_aligned  = {data_masked, {(BUF_W - IN_W){1'b0}}} >> cnt_after;
  end

  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    trunc_err  = 1'b0;
    case (state)
      RUN:     if (in_valid && in_ready && in_last) state_nxt = FLUSH;
      FLUSH:   if (!match_valid && !out_valid) state_nxt = DONE;
      DONE: begin
        frame_done = 1'b1;
        trunc_err  = (count != '0);
        state_nxt  = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      bit_buf <= '0;
      count   <= '0;
    end else begin
      state <= state_nxt;
      if (state == DONE) begin
        bit_buf <= '0;
        count   <= '0;
      end else begin
        bit_buf <= buf_shift | (accept ? in_aligned : '0);
        count   <= cnt_after + (accept ? CW'(in_nbits) : '0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_symbol <= '0;
      out_length <= '0;
      sym_count  <= '0;
      new_frame  <= 1'b1;
    end else begin
      if (fire) begin
        out_valid  <= 1'b1;
        out_symbol <= m_sym;
        out_length <= m_len;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept && new_frame) sym_count <= '0;
      else if (handshake)      sym_count <= sym_count + 1'b1;
      if (state == DONE) new_frame <= 1'b1;
      else if (accept)   new_frame <= 1'b0;
    end
  end

endmodule

// File: tb/tb_huffman_stream_decoder.sv
// Directed self-checking bench for huffman_stream_decoder.
module tb_huffman_stream_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last;
  logic [5:0]  in_data;
  logic [2:0]  in_nbits;
  logic        out_valid, out_ready;
  logic [3:0]  out_symbol;
  logic [2:0]  out_length;
  logic        frame_done, trunc_err;
  logic [15:0] sym_count;

  huffman_stream_decoder #(.IN_W(6), .BUF_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_nbits(in_nbits), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_symbol(out_symbol), .out_length(out_length),
    .frame_done(frame_done), .trunc_err(trunc_err), .sym_count(sym_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;
  int cyc = 0, fd_cnt = 0, fd_cyc = 0, stall_viol = 0, stall_cnt = 0, orphan = 0;
  int wait_cycles = 0;
  logic fd_trunc;
  logic [15:0] fd_symcnt;
  int sym_q[$], len_q[$], cyc_q[$];
  logic prev_stall = 1'b0;
  logic [3:0] p_sym;
  logic [2:0] p_len;
  logic toggle_mode = 1'b0;

  int t_code[14] = '{1, 7, 5, 4, 3, 2, 0, 13, 24, 25, 6, 7, 4, 5};
  int t_len[14]  = '{1, 4, 4, 4, 4, 4, 4, 5, 6, 6, 6, 6, 6, 6};
  int t_sym[14]  = '{0, 9, 2, 1, 6, 5, 10, 7, 3, 4, 8, 12, 14, 15};

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (prev_stall && (out_valid !== 1'b1 || out_symbol !== p_sym || out_length !== p_len))
        stall_viol++;
      prev_stall = out_valid && !out_ready;
      if (prev_stall) stall_cnt++;
      p_sym = out_symbol;
      p_len = out_length;
      if (out_valid && out_ready) begin
        sym_q.push_back(int'(out_symbol));
        len_q.push_back(int'(out_length));
        cyc_q.push_back(cyc);
      end
      if (frame_done) begin
        fd_cnt++;
        fd_trunc  = trunc_err;
        fd_symcnt = sym_count;
        fd_cyc    = cyc;
      end
      if (trunc_err && !frame_done) orphan++;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Consumer stall pattern 1,0,0,1 when enabled.
  initial begin
    int pidx = 0;
    forever begin
      @(posedge clk); #1;
      if (toggle_mode) begin
        out_ready = (pidx == 0 || pidx == 3);
        pidx = (pidx + 1) % 4;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [5:0] d, input int nb, input logic last);
    logic done = 1'b0;
    in_valid = 1'b1; in_data = d; in_nbits = 3'(nb); in_last = last;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        done = 1'b1;
      end else wait_cycles++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (!done) begin
      n_checks++;
      $display("FAIL send_timeout: in_ready never asserted for chunk %b", d);
    end
  endtask

  task automatic wait_frame(input int prev, output int cycles);
    cycles = 0;
    while (fd_cnt == prev && cycles < 400) begin
      @(negedge clk); #1;
      cycles++;
    end
    n_checks++;
    if (fd_cnt == prev) $display("FAIL frame_timeout: frame_done never seen");
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic clear_q();
    sym_q.delete(); len_q.delete(); cyc_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_nbits = '0; in_last = 1'b0; out_ready = 1'b1;
    #2;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (out_symbol !== 4'd0) $display("FAIL rst_out_symbol: got %0d expected 0", out_symbol); else n_pass++;
    n_checks++; if (out_length !== 3'd0) $display("FAIL rst_out_length: got %0d expected 0", out_length); else n_pass++;
    n_checks++; if (frame_done !== 1'b0 || trunc_err !== 1'b0) $display("FAIL rst_frame_flags: got %b%b expected 00", frame_done, trunc_err); else n_pass++;
    n_checks++; if (sym_count !== 16'd0) $display("FAIL rst_sym_count: got %0d expected 0", sym_count); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", in_ready); else n_pass++;
    #20 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_basic4(input string tag);
    int e_sym[4] = '{0, 9, 7, 3};
    int e_len[4] = '{1, 4, 5, 6};
    n_checks++; if (sym_q.size() != 4) $display("FAIL %s_count: got %0d symbols expected 4", tag, sym_q.size()); else n_pass++;
    for (int i = 0; i < 4 && i < sym_q.size(); i++) begin
      n_checks++;
      if (sym_q[i] != e_sym[i] || len_q[i] != e_len[i])
        $display("FAIL %s_sym%0d: got %0d/%0d expected %0d/%0d", tag, i, sym_q[i], len_q[i], e_sym[i], e_len[i]);
      else n_pass++;
    end
    n_checks++; if (fd_trunc !== 1'b0) $display("FAIL %s_trunc: got %b expected 0", tag, fd_trunc); else n_pass++;
    n_checks++; if (fd_symcnt !== 16'd4) $display("FAIL %s_symcnt: got %0d expected 4", tag, fd_symcnt); else n_pass++;
  endtask

  task automatic test_basic();
    int cy;
    int f0 = fd_cnt;
    clear_q();
    send(6'b101110, 6, 1'b0);
    send(6'b110101, 6, 1'b0);
    send(6'b100011, 4, 1'b1);
    wait_frame(f0, cy);
    check_basic4("basic");
    n_checks++; if (sym_count !== 16'd4) $display("FAIL basic_symcnt_hold: got %0d expected 4", sym_count); else n_pass++;
  endtask

  task automatic test_throughput();
    int cy, bad = 0;
    int f0 = fd_cnt;
    clear_q();
    for (int k = 0; k < 6; k++) send(6'b111111, 6, k == 5);
    wait_frame(f0, cy);
    n_checks++; if (sym_q.size() != 36) $display("FAIL tput_count: got %0d symbols expected 36", sym_q.size()); else n_pass++;
    for (int i = 0; i < sym_q.size(); i++) if (sym_q[i] != 0 || len_q[i] != 1) bad++;
    n_checks++; if (bad != 0) $display("FAIL tput_values: got %0d wrong symbols expected 0", bad); else n_pass++;
    if (cyc_q.size() == 36) begin
      n_checks++;
      if (cyc_q[35] - cyc_q[0] != 35) $display("FAIL tput_rate: got span %0d expected 35", cyc_q[35] - cyc_q[0]);
      else n_pass++;
    end
    n_checks++; if (fd_symcnt !== 16'd36 || fd_trunc !== 1'b0) $display("FAIL tput_frame: got %0d/%b expected 36/0", fd_symcnt, fd_trunc); else n_pass++;
  endtask

  task automatic test_backpressure();
    int cy;
    int f0 = fd_cnt;
    clear_q();
    stall_viol = 0; stall_cnt = 0; wait_cycles = 0;
    toggle_mode = 1'b1;
    send(6'b101110, 6, 1'b0);
    send(6'b110101, 6, 1'b0);
    send(6'b100000, 4, 1'b1);
    wait_frame(f0, cy);
    toggle_mode = 1'b0; out_ready = 1'b1;
    check_basic4("bp");
    n_checks++; if (stall_cnt == 0) $display("FAIL bp_stalls: got %0d stall cycles expected >0", stall_cnt); else n_pass++;
    n_checks++; if (stall_viol != 0) $display("FAIL bp_stable: got %0d unstable stalls expected 0", stall_viol); else n_pass++;
    n_checks++; if (wait_cycles == 0) $display("FAIL bp_in_ready: got %0d not-ready cycles expected >0", wait_cycles); else n_pass++;
  endtask

  task automatic test_truncation();
    int cy;
    int f0 = fd_cnt;
    clear_q();
    send(6'b011101, 3, 1'b1);
    wait_frame(f0, cy);
    n_checks++; if (sym_q.size() != 0) $display("FAIL trunc_nosym: got %0d symbols expected 0", sym_q.size()); else n_pass++;
    n_checks++; if (fd_trunc !== 1'b1) $display("FAIL trunc_flag: got %b expected 1", fd_trunc); else n_pass++;
    n_checks++; if (fd_symcnt !== 16'd0) $display("FAIL trunc_symcnt: got %0d expected 0", fd_symcnt); else n_pass++;
    n_checks++; if (cy != 2) $display("FAIL trunc_latency: got %0d cycles expected 2", cy); else n_pass++;
    n_checks++; if (orphan != 0) $display("FAIL trunc_orphan: got %0d lone trunc_err expected 0", orphan); else n_pass++;
  endtask

  task automatic test_empty_last();
    int cy;
    int f0 = fd_cnt;
    clear_q();
    send(6'b000000, 0, 1'b1);
    wait_frame(f0, cy);
    n_checks++; if (sym_q.size() != 0 || fd_trunc !== 1'b0 || fd_symcnt !== 16'd0)
      $display("FAIL empty_last: got %0d syms trunc %b cnt %0d expected 0/0/0", sym_q.size(), fd_trunc, fd_symcnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int cy, f0;
    f0 = fd_cnt;
    clear_q();
    send(6'b000110, 6, 1'b0);
    send(6'b000111, 6, 1'b1);
    wait_frame(f0, cy);
    n_checks++; if (sym_q.size() != 2) $display("FAIL long_count: got %0d expected 2", sym_q.size()); else n_pass++;
    if (sym_q.size() == 2) begin
      n_checks++;
      if (sym_q[0] != 8 || sym_q[1] != 12 || len_q[0] != 6 || len_q[1] != 6)
        $display("FAIL long_syms: got %0d/%0d %0d/%0d expected 8/6 12/6", sym_q[0], len_q[0], sym_q[1], len_q[1]);
      else n_pass++;
    end
    clear_q();
    out_ready = 1'b0;
    send(6'b011101, 6, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    n_checks++; if (out_valid !== 1'b1) $display("FAIL midflush_held: got %b expected 1", out_valid); else n_pass++;
    f0 = fd_cnt;
    rst = 1'b1; #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); else n_pass++;
    n_checks++; if (sym_count !== 16'd0) $display("FAIL rstmid_symcnt: got %0d expected 0", sym_count); else n_pass++;
    repeat (2) begin @(posedge clk); #1; end
    #3 rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    n_checks++; if (fd_cnt != f0) $display("FAIL rstmid_no_done: got %0d frames expected %0d", fd_cnt, f0); else n_pass++;
    n_checks++; if (sym_q.size() != 0 || out_valid !== 1'b0) $display("FAIL rstmid_discard: got %0d syms ov %b expected 0/0", sym_q.size(), out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rstmid_ready_after: got %b expected 1", in_ready); else n_pass++;
  endtask

  task automatic test_all_codes();
    logic [65:0] s;
    int p = 66, cy, bad = 0;
    int f0 = fd_cnt;
    clear_q();
    s = '0;
    for (int i = 0; i < 14; i++)
      for (int b = t_len[i] - 1; b >= 0; b--) begin
        p--;
        s[p] = 1'((t_code[i] >> b) & 1);
      end
    for (int k = 0; k < 11; k++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      send(s[65 - 6*k -: 6], 6, k == 10);
    end
    wait_frame(f0, cy);
    n_checks++; if (sym_q.size() != 14) $display("FAIL all_count: got %0d expected 14", sym_q.size()); else n_pass++;
    for (int i = 0; i < 14 && i < sym_q.size(); i++)
      if (sym_q[i] != t_sym[i] || len_q[i] != t_len[i]) begin
        bad++;
        $display("FAIL all_sym%0d: got %0d/%0d expected %0d/%0d", i, sym_q[i], len_q[i], t_sym[i], t_len[i]);
      end
    n_checks++; if (bad == 0) n_pass++;
    n_checks++; if (fd_symcnt !== 16'd14 || fd_trunc !== 1'b0) $display("FAIL all_frame: got %0d/%b expected 14/0", fd_symcnt, fd_trunc); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_throughput();
    test_backpressure();
    test_truncation();
    test_empty_last();
    test_reset_mid_frame();
    test_all_codes();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/huffman_stream_decoder.md
Name: huffman_stream_decoder

Overview:
- Streaming, parametrised successor to the fixed 6-bit two-register Huffman decoder.
- Accepts packed codeword chunks of IN_W bits (the last chunk may be partial) into a bit buffer, and decodes up to one symbol per clock.
- Uses valid/ready handshakes on input and output, and reports end-of-frame (symbol count, truncation error).
- Sits between the compressed-stream reader and the symbol consumer.

Parameters:
- IN_W, 6, input chunk width in bits.
- BUF_W, 16, bit-buffer capacity; must be >= IN_W + huff_pkg::MAX_LEN (elaboration error otherwise).
- CNT_W, 16, width of the per-frame symbol counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  chunk present.
- in_ready  out  1  chunk accepted when in_valid && in_ready.
- in_data  in  IN_W  chunk; first bit is the MSB.
- in_nbits  in  $clog2(IN_W+1)  valid bits in in_data, MSB-aligned; 1..IN_W; 0 is allowed only with in_last.
- in_last  in  1  chunk ends the frame.
- out_valid  out  1  decoded symbol present.
- out_ready  in  1  consumer takes the symbol.
- out_symbol  out  4  decoded symbol.
- out_length  out  $clog2(MAX_LEN+1)  codeword length of out_symbol.
- frame_done  out  1  one-cycle pulse at end of frame.
- trunc_err  out  1  one-cycle pulse, coincident with frame_done, when leftover bits formed no complete code.
- sym_count  out  CNT_W  symbols emitted in the current/last frame.

Behaviour:
- Reset (async): count=0, buffer=0, state=RUN, out_valid=0, out_symbol=0, out_length=0, frame_done=0, trunc_err=0, sym_count=0.
- Code table (MSB first): 1->0
  - 4-bit: 0111->9, 0101->2, 0100->1, 0011->6, 0010->5, 0000->10
  - 5-bit: 01101->7
  - 6-bit: 011000->3, 011001->4, 000110->8, 000111->12, 000100->14, 000101->15
  - The table is complete (Kraft sum = 1), so every 6-bit prefix matches exactly one code.
- Buffer: MSB-aligned, with count of valid bits. The matcher inspects buf[BUF_W-1 -: MAX_LEN].
  - Match is valid only if the matched length <= count.
  - Bits beyond count are treated as 0.
- in_ready = (state==RUN) && (count <= BUF_W-IN_W), computed from the registered count. It reads 1 while rst is asserted.
- Decode fire = match valid && (!out_valid || out_ready).
  - On fire, the output registers load symbol/length next edge, out_valid=1, and the buffer shifts left by length.
- Output register semantics:
  - out_valid held with data stable until out_ready.
  - out_valid clears on out_ready with no new fire.
  - Latency: chunk accepted at edge N gives its first symbol out_valid at edge N+1 at earliest.
  - Throughput: 1 symbol/cycle.
- Simultaneous accept and fire: new count = count - length + in_nbits. Incoming bits are placed immediately below the surviving bits.
- sym_count increments on each out_valid && out_ready handshake. It clears on the first accepted chunk of a new frame, i.e. the first accept after DONE or after reset.
- FSM:
  - RUN: accepting. An accepted chunk with in_last moves to FLUSH.
  - FLUSH: in_ready=0. Keep decoding while a match is valid. Once no match is valid and out_valid=0 (all symbols handed over), go to DONE.
  - DONE: one cycle. frame_done=1; trunc_err=(count!=0); count and buffer cleared; go to RUN.
- Boundaries:
  - Full buffer: in_ready=0; no overflow possible.
  - Empty buffer: no fire, out_valid drops after handshake.
  - in_last with in_nbits=0: legal, ends the frame.
  - Backpressure during FLUSH: DONE waits.
  - Reset mid-frame: everything returns to reset values immediately; partial symbols are discarded and no frame_done is raised.

Decomposition:
- huff_pkg holds:
  - MAX_LEN=6 and SYM_W=4
  - the code table as constant arrays (code, length, symbol)
  - the state enum {RUN, FLUSH, DONE}
- Sub-module huff_code_match: combinational. Input MAX_LEN-bit window; outputs symbol and length. Unit-testable on its own.

Test Plan:
- Chunks 101110, 110101, 1000 (nbits=4, last), out_ready=1 -> symbols 0/1, 9/4, 7/5, 3/6 in order. frame_done pulse, trunc_err=0, sym_count=4.
- Six chunks of 111111 (last on the sixth) -> 36 symbols of 0, length 1, at 1/cycle after fill. sym_count=36, no truncation.
- The first test with out_ready toggling 1,0,0,1 repeatedly -> out_symbol/out_length held stable while stalled. Identical symbol sequence; in_ready drops when count>10.
- Single chunk 011xxx with nbits=3, last -> no out_valid. frame_done and trunc_err pulse together ~2 cycles after accept; sym_count=0.
- Chunk 000110 then 000111, last -> symbols 8 then 12, length 6. Then assert rst during a second frame mid-FLUSH -> out_valid=0, count=0, no frame_done, in_ready=1 after release.
- All 14 codes concatenated, fed in IN_W=6 chunks with random in_valid gaps -> exact symbol/length match against the table; sym_count=14.
